fxp_result_streamer: RTL and testbench
======================================

// Module: fxp_result_streamer
// PURPOSE
// Reader end of the Cumulative_Fxp/Batch filter output interface (out + valid). Captures each valid
// fixed-point estimate into a FIFO and streams it as MSB-first, sign-extended bytes on a ready/valid
// byte link toward the capture/host side. Decouples filter output bursts (DSR>1) from a slow consumer.
// PARAMETERS
// OUT_W       14  width of filter result word (two's complement)
// FIFO_DEPTH  16  result words buffered; power of two, >=2
// BYTE_W      8   width of output stream symbol
// (derived) NB = ceil(OUT_W/BYTE_W) bytes per word; CNT_W = $clog2(FIFO_DEPTH+1)
// PORTS
// clk        in   1        clock; all logic on rising edge
// rst        in   1        asynchronous, active-high reset
// in_result  in   OUT_W    filter estimate, sampled when in_valid=1
// in_valid   in   1        filter result strobe (no backpressure toward filter)
// out_data   out  BYTE_W   current byte of stream
// out_valid  out  1        out_data valid
// out_ready  in   1        consumer accepts byte when out_valid & out_ready
// out_last   out  1        high with final byte (byte NB-1) of each word
// fill       out  CNT_W    words held in FIFO (excludes word in serializer)
// overflow   out  1        sticky: a result was dropped
// clr_ovf    in   1        synchronous clear of overflow
// BEHAVIOUR
// - Reset (async assert, sync release): out_valid=0, out_last=0, out_data=0, fill=0, overflow=0,
//   FIFO pointers 0, state IDLE, byte_cnt=0.
// - Write: in_valid=1 and (fill<FIFO_DEPTH or pop same cycle) -> word written at that edge.
//   in_valid=1, fill==FIFO_DEPTH, no pop -> word dropped, overflow<=1. Full+pop+write: write accepted, fill unchanged.
// - overflow: set by drop, cleared by clr_ovf; drop and clr_ovf same cycle -> overflow=1.
// - Word formatting: sign-extend in_result to NB*BYTE_W bits; byte k = bits [(NB-k)*BYTE_W-1 -: BYTE_W], k=0 first.
// - FSM IDLE: out_valid=0. If fill>0: pop head into shift reg, byte_cnt<=0, -> SEND.
// - FSM SEND: out_valid=1, out_data=byte[byte_cnt], out_last=(byte_cnt==NB-1).
//   No out_ready: hold all outputs stable (out_data must not change while out_valid & !out_ready).
//   out_ready & byte_cnt<NB-1: byte_cnt++.
//   out_ready & byte_cnt==NB-1: if fill>0 pop next word, byte_cnt<=0, stay SEND (no bubble); else -> IDLE.
// - Latency: in_valid in cycle t with empty FIFO and IDLE -> out_valid=1 with byte 0 in cycle t+2.
// - Sustained throughput 1 byte/clk with out_ready=1; fill never goes negative; pop only when fill>0.
// - Pointers wrap modulo FIFO_DEPTH; fill computed from counter, exact at full and empty.
// - Serializer word is not counted in fill; total capacity = FIFO_DEPTH+1 words.
// - Reset mid-word: stream aborts immediately, partial word lost, no out_valid after assert.
// TESTING
// 1 Single word: OUT_W=14, in_result=14'h2ABC (negative) one cycle, out_ready=1 -> bytes 8'hEA,8'hBC,
//   out_valid first in t+2, out_last on 2nd byte, then IDLE, fill=0.
// 2 Backpressure: out_ready=0 for 5 cycles while out_valid -> out_data/out_last stable; release -> same 2 bytes, no dup.
// 3 Burst: 4 consecutive in_valid words 1,2,3,4, out_ready=1 -> 8 bytes back-to-back 00,01,00,02,00,03,00,04, no gap.
// 4 Overflow: out_ready=0, write 18 words (DEPTH 16) -> first 17 kept (1 serializer+16), fill=16, overflow=1;
//   drain -> exactly 17 words in order; clr_ovf -> overflow=0.
// 5 Full+pop+write: fill=16, final byte accepted same cycle as in_valid -> no drop, fill stays 16, overflow=0.
// 6 Reset mid-word after byte 0 -> out_valid=0 immediately, fill=0; new word afterward streams normally.

Source files
------------

// File: rtl/fxp_result_streamer.sv
// Buffers filter results in a FIFO and streams each word as MSB-first, sign-extended bytes
// over a ready/valid byte link. Serializer holds one word beyond the FIFO capacity.
module fxp_result_streamer #(
    parameter  int unsigned OUT_W      = 14,
    parameter  int unsigned FIFO_DEPTH = 16,
    parameter  int unsigned BYTE_W     = 8,
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OUT_W-1:0]  in_result,
    input  logic              in_valid,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [CNT_W-1:0]  fill,
    output logic              overflow,
    input  logic              clr_ovf
);

    localparam int unsigned NB  = (OUT_W + BYTE_W - 1) / BYTE_W;
    localparam int unsigned WW  = NB * BYTE_W;
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned BCW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic {IDLE, SEND} state_e;

    state_e            state_q, state_d;
    logic [OUT_W-1:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  fill_q, fill_d;
    logic              ovf_q, ovf_d;
    logic [WW-1:0]     sh_q, sh_d, head_word;
    logic [BCW-1:0]    cnt_q, cnt_d;
    logic [BYTE_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              fill_nz, load, pop, push;

    assign fill_nz   = (fill_q != '0);
    assign head_word = WW'($signed(mem_q[rd_ptr_q]));
    assign push      = in_valid & ((fill_q != CNT_W'(FIFO_DEPTH)) | pop);

    // sh_q holds the bytes still to be sent after the one presented on out_data
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = 1'b0;
        last_d  = 1'b0;
        load    = 1'b0;
        unique case (state_q)
            IDLE: load = fill_nz;
            SEND: begin
                valid_d = 1'b1;
                last_d  = last_q;
                if (out_ready) begin
                    if (cnt_q != BCW'(NB - 1)) begin
                        cnt_d  = cnt_q + 1'b1;
                        data_d = sh_q[WW-1 -: BYTE_W];
                        sh_d   = sh_q << BYTE_W;
                        last_d = (cnt_d == BCW'(NB - 1));
                    end else if (fill_nz) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        pop = load;
        if (load) begin
            data_d  = head_word[WW-1 -: BYTE_W];
            sh_d    = head_word << BYTE_W;
            cnt_d   = '0;
            valid_d = 1'b1;
            last_d  = (NB == 1);
            state_d = SEND;
        end
    end

    always_comb begin
        fill_d = fill_q;
        if (push && !pop) begin
            fill_d = fill_q + 1'b1;
        end else if (pop && !push) begin
            fill_d = fill_q - 1'b1;
        end
    end

    // A drop in the same cycle as a clear wins
    assign ovf_d = (in_valid & ~push) | (ovf_q & ~clr_ovf);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            ovf_q    <= 1'b0;
            sh_q     <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            ovf_q   <= ovf_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_result;
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign fill      = fill_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_fxp_result_streamer.sv
// Scoreboard bench for fxp_result_streamer: a word-level occupancy model predicts accepted
// words, fill and overflow; a negedge monitor checks every handshaken byte against the queue.
module tb_fxp_result_streamer;

    localparam int unsigned OUT_W = 14;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned BW    = 8;
    localparam int unsigned NB    = 2;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [OUT_W-1:0] in_result = '0;
    logic             in_valid = 1'b0;
    logic [BW-1:0]    out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             out_last;
    logic [CNT_W-1:0] fill;
    logic             overflow;
    logic             clr_ovf = 1'b0;

    fxp_result_streamer #(.OUT_W(OUT_W), .FIFO_DEPTH(DEPTH), .BYTE_W(BW)) dut (
        .clk(clk), .rst(rst), .in_result(in_result), .in_valid(in_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .fill(fill), .overflow(overflow), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int words_seen = 0;

    // expected stream entries: {last, byte}
    logic [BW:0] exp_q [$];

    // word-level model: words waiting, whether a word is being sent, bytes left of it
    int m_size = 0;
    bit m_busy = 1'b0;
    int m_rem  = 0;
    bit m_ovf  = 1'b0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void expect_word(input int w);
        longint v;
        longint u;
        logic [BW-1:0] b;
        v = w;
        if (v >= (longint'(1) << (OUT_W - 1))) v = v - (longint'(1) << OUT_W);
        u = v;
        if (u < 0) u = u + (longint'(1) << (NB * BW));
        for (int k = 0; k < int'(NB); k++) begin
            b = BW'((u >> ((int'(NB) - 1 - k) * int'(BW))) & 255);
            exp_q.push_back({(k == int'(NB) - 1), b});
        end
    endfunction

    always @(posedge clk) begin
        bit hs, pop, push;
        if (rst) begin
            m_size = 0; m_busy = 1'b0; m_rem = 0; m_ovf = 1'b0;
            exp_q.delete();
        end else begin
            hs   = m_busy && out_ready;
            pop  = (m_size > 0) && (!m_busy || (hs && m_rem == 1));
            push = in_valid && (m_size < int'(DEPTH) || pop);
            if (push) expect_word(int'(in_result));
            if (in_valid && !push) m_ovf = 1'b1;
            else if (clr_ovf)      m_ovf = 1'b0;
            if (!m_busy) begin
                if (pop) begin m_busy = 1'b1; m_rem = NB; end
            end else if (hs) begin
                if (m_rem > 1)  m_rem--;
                else if (pop)   m_rem = NB;
                else            m_busy = 1'b0;
            end
            m_size = m_size + int'(push) - int'(pop);
        end
    end

    bit            prev_stall = 1'b0;
    logic [BW-1:0] prev_data;
    logic          prev_last;

    always @(negedge clk) begin
        logic [BW:0] e;
        if (rst) begin
            chk("valid_in_reset", out_valid, 0);
            prev_stall = 1'b0;
        end else begin
            chk("out_valid", out_valid, m_busy);
            chk("fill", fill, m_size);
            chk("overflow", overflow, m_ovf);
            if (prev_stall && out_valid) begin
                chk("stall_data", out_data, prev_data);
                chk("stall_last", out_last, prev_last);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", out_data, -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("byte", out_data, e[BW-1:0]);
                    chk("last", out_last, e[BW]);
                    if (out_last) words_seen++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; clr_ovf = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic send_word(input int w);
        in_valid  = 1'b1;
        in_result = OUT_W'(w);
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || m_busy || m_size != 0) && n < 400) begin
            tick();
            n++;
        end
        chk("drain_timeout", n < 400, 1);
        tick();
    endtask

    initial begin
        logic [BW-1:0] hold_data;
        logic          hold_last;
        int nv, first, lastc, w0;

        do_reset();
        chk("rst_fill", fill, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_last", out_last, 0);

        // single negative word, latency t+2
        out_ready = 1'b1;
        send_word(14'h2ABC);
        chk("lat_t1_valid", out_valid, 0);
        tick();
        chk("lat_t2_valid", out_valid, 1);
        chk("lat_t2_byte0", out_data, 8'hEA);
        chk("lat_t2_last", out_last, 0);
        tick();
        chk("t3_byte1", out_data, 8'hBC);
        chk("t3_last", out_last, 1);
        tick();
        chk("t4_idle", out_valid, 0);
        chk("t4_fill", fill, 0);

        // backpressure
        out_ready = 1'b0;
        send_word(14'h0123);
        tick();
        chk("bp_valid", out_valid, 1);
        hold_data = out_data;
        hold_last = out_last;
        repeat (5) begin
            tick();
            chk("bp_hold_data", out_data, hold_data);
            chk("bp_hold_last", out_last, hold_last);
        end
        w0 = words_seen;
        drain();
        chk("bp_words", words_seen - w0, 1);

        // burst of four, no bubble
        out_ready = 1'b1;
        nv = 0; first = -1; lastc = -1;
        for (int i = 0; i < 12; i++) begin
            in_valid  = (i < 4);
            in_result = OUT_W'(i + 1);
            tick();
            if (out_valid) begin
                nv++;
                if (first < 0) first = i;
                lastc = i;
            end
        end
        in_valid = 1'b0;
        chk("burst_bytes", nv, 8);
        chk("burst_span", lastc - first, 7);

        // overflow: 18 words into a stalled stream
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 18; i++) send_word(100 + i);
        chk("ovf_fill", fill, DEPTH);
        chk("ovf_flag", overflow, 1);
        w0 = words_seen;
        drain();
        chk("ovf_words", words_seen - w0, 17);
        chk("ovf_sticky", overflow, 1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("ovf_clear", overflow, 0);

        // full + pop + write in the same cycle
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 17; i++) send_word(14'h3F00 + i);
        chk("fpw_full", fill, DEPTH);
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b1;
        in_result = 14'h1555;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("fpw_fill", fill, DEPTH);
        chk("fpw_ovf", overflow, 0);
        drain();

        // reset mid-word after byte 0
        out_ready = 1'b1;
        send_word(14'h0ABC);
        tick();
        chk("rmw_valid", out_valid, 1);
        tick();
        rst = 1'b1;
        #1;
        chk("rmw_valid_rst", out_valid, 0);
        chk("rmw_fill_rst", fill, 0);
        tick();
        rst = 1'b0;
        tick();
        send_word(14'h1234);
        tick();
        chk("rmw_new_byte0", out_data, 8'h12);
        drain();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(99) < 45);
            in_result = OUT_W'($urandom);
            out_ready = ($urandom_range(99) < ((i / 500) % 2 == 0 ? 30 : 80));
            clr_ovf   = ($urandom_range(99) < 3);
            tick();
        end
        in_valid = 1'b0;
        clr_ovf  = 1'b0;
        drain();
        chk("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_err);
        $fatal(1);
    end

endmodule
